// File: rtl/interrupt_controller.sv
// interrupt_controller
//   Prioritised, nestable interrupt controller for the MPU341 core. Request
//   edges on four external lines are synchronised, latched as pending and
//   gated by a mask register. At an instruction boundary the highest-priority
//   eligible line (line 0 highest) is taken: the sequencer is told to jump to
//   the line's vector, and {pm_address, id} is pushed on a 4-deep return
//   stack. A return-from-interrupt pops the stack and hands the sequencer the
//   saved address.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   irq_in[3:0]    external request lines (asynchronous), rising edge requests
//   mask_we        mask register write strobe
//   mask_data[3:0] new mask value, 1 blocks the line
//   pm_address[7:0] current program counter
//   instr_boundary sequencer fetches a new instruction next cycle
//   rti            return-from-interrupt executing (one-cycle pulse)
//   int_take       one-cycle pulse, load int_vector as next pm_address
//   int_vector[7:0] handler address, valid with int_take
//   ret_valid      one-cycle pulse, load ret_addr as next pm_address
//   ret_addr[7:0]  popped return address, valid with ret_valid
//   in_service[3:0] lines whose handlers are active
//   mask_reg[3:0]  current mask
//   err_underflow  sticky: rti seen with an empty return stack
module interrupt_controller #(
  parameter logic [7:0] VEC_BASE   = 8'hF0,
  parameter logic [7:0] VEC_STRIDE = 8'h04
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] irq_in,
  input  logic       mask_we,
  input  logic [3:0] mask_data,
  input  logic [7:0] pm_address,
  input  logic       instr_boundary,
  input  logic       rti,
  output logic       int_take,
  output logic [7:0] int_vector,
  output logic       ret_valid,
  output logic [7:0] ret_addr,
  output logic [3:0] in_service,
  output logic [3:0] mask_reg,
  output logic       err_underflow
);

  typedef enum logic [1:0] {
    IDLE,
    VECTOR,
    BLOCK
  } state_t;

  state_t     state, state_next;

  logic [3:0] sync_a, sync_b, sync_prev;
  logic [3:0] rise;
  logic [3:0] pending;
  logic [3:0] below_mask;
  logic [3:0] eligible;
  logic [1:0] sel_id;
  logic [7:0] vector_calc;

  // Return stack: sp counts valid entries (0..4), entry sp-1 is the top.
  logic [2:0] sp;
  logic [7:0] stack_pc [4];
  logic [1:0] stack_id [4];
  logic [1:0] top_idx;
  logic [1:0] pop_id;

  logic       take;
  logic       pop;
  logic       underflow;
  logic [3:0] take_onehot;
  logic [3:0] pop_onehot;

  always_comb rise = sync_b & ~sync_prev;

  // Only lines strictly higher in priority than the lowest-numbered active
  // handler may preempt it; with nothing in service every line qualifies.
  always_comb begin
    below_mask = 4'b1111;
    for (int unsigned i = 0; i < 4; i++) begin
      if (in_service[3 - i]) below_mask = (4'b0001 << (3 - i)) - 4'b0001;
    end
  end

  always_comb eligible = pending & ~mask_reg & below_mask;

  // Scan from line 3 down so the lowest set bit is the last one written.
  always_comb begin
    sel_id = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (eligible[3 - i]) sel_id = 2'(3 - i);
    end
  end

  always_comb vector_calc = VEC_BASE + ({6'd0, sel_id} * VEC_STRIDE);

  always_comb begin
    top_idx   = sp[1:0] - 2'd1;
    pop_id    = stack_id[top_idx];
    // rti has priority over a take in the same cycle.
    take      = (state == IDLE) && instr_boundary && (eligible != '0) && !rti;
    pop       = rti && (sp != '0);
    underflow = rti && (sp == '0);
    take_onehot = take ? (4'b0001 << sel_id) : '0;
    pop_onehot  = pop  ? (4'b0001 << pop_id) : '0;
  end

  // FSM next state and the take pulse.
  always_comb begin
    state_next = state;
    int_take   = 1'b0;
    unique case (state)
      IDLE: begin
        if (take) state_next = VECTOR;
      end
      VECTOR: begin
        int_take   = 1'b1;
        state_next = BLOCK;
      end
      BLOCK: begin
        if (instr_boundary) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Synchronisers, edge capture, pending and mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a    <= '0;
      sync_b    <= '0;
      sync_prev <= '0;
      pending   <= '0;
      mask_reg  <= '0;
    end else begin
      sync_a    <= irq_in;
      sync_b    <= sync_a;
      sync_prev <= sync_b;
      pending   <= (pending & ~take_onehot) | rise;
      if (mask_we) mask_reg <= mask_data;
    end
  end

  // Return stack, in-service tracking and sequencer handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp            <= '0;
      in_service    <= '0;
      int_vector    <= '0;
      ret_valid     <= 1'b0;
      ret_addr      <= '0;
      err_underflow <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        stack_pc[i] <= '0;
        stack_id[i] <= '0;
      end
    end else begin
      ret_valid  <= pop;
      in_service <= (in_service | take_onehot) & ~pop_onehot;
      if (underflow) err_underflow <= 1'b1;
      if (take) begin
        int_vector           <= vector_calc;
        stack_pc[sp[1:0]]    <= pm_address;
        stack_id[sp[1:0]]    <= sel_id;
        sp                   <= sp + 3'd1;
      end else if (pop) begin
        ret_addr <= stack_pc[top_idx];
        sp       <= sp - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_data;
  logic [7:0] pm_address;
  logic       instr_boundary;
  logic       rti;

  logic       take_a, rv_a, err_a;
  logic [7:0] vec_a, ra_a;
  logic [3:0] isv_a, msk_a;
  logic       take_b, rv_b, err_b;
  logic [7:0] vec_b, ra_b;
  logic [3:0] isv_b, msk_b;

  always #5 clk = ~clk;

  interrupt_controller dut_a (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we),
    .mask_data(mask_data), .pm_address(pm_address),
    .instr_boundary(instr_boundary), .rti(rti),
    .int_take(take_a), .int_vector(vec_a), .ret_valid(rv_a), .ret_addr(ra_a),
    .in_service(isv_a), .mask_reg(msk_a), .err_underflow(err_a)
  );

  interrupt_controller #(.VEC_BASE(8'hFE), .VEC_STRIDE(8'h04)) dut_b (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we),
    .mask_data(mask_data), .pm_address(pm_address),
    .instr_boundary(instr_boundary), .rti(rti),
    .int_take(take_b), .int_vector(vec_b), .ret_valid(rv_b), .ret_addr(ra_b),
    .in_service(isv_b), .mask_reg(msk_b), .err_underflow(err_b)
  );

  int total = 0;
  int bad   = 0;
  int unsigned edge_n = 0;
  bit mon_on = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] pc;
    int         id;
  } frame_t;

  typedef struct {
    int unsigned at;   // posedge index after which the pulse is visible
    logic [7:0]  val;
    int          id;
  } exp_t;

  frame_t     m_stack[$];
  exp_t       take_q[$];
  exp_t       ret_q[$];
  logic [3:0] m_pend, m_mask, m_insvc;
  logic       m_err;
  int         phase;        // 0: may take, 1: pulse cycle, 2: waiting for boundary
  logic [3:0] p1, p2, p3;   // irq_in seen at the previous 1, 2, 3 edges
  logic [3:0] cur_irq;

  function automatic logic [7:0] vec(input int base, input int id);
    int v;
    v = (base + id * 4) % 256;
    return v[7:0];
  endfunction

  task automatic model_reset();
    m_stack.delete();
    take_q.delete();
    ret_q.delete();
    m_pend  = '0;
    m_mask  = '0;
    m_insvc = '0;
    m_err   = 1'b0;
    phase   = 0;
    p1 = '0; p2 = '0; p3 = '0;
  endtask

  // Advance the model across the upcoming rising edge using the inputs now applied.
  task automatic model_step();
    int unsigned up;
    logic [3:0]  rise_m;
    int          sel;
    bit          blocked;
    int          old_phase;
    frame_t      f;
    up     = edge_n + 1;
    rise_m = p2 & ~p3;
    sel    = -1;
    for (int i = 3; i >= 0; i--) begin
      blocked = 1'b0;
      for (int j = 0; j <= i; j++) if (m_insvc[j]) blocked = 1'b1;
      if (m_pend[i] && !m_mask[i] && !blocked) sel = i;
    end
    old_phase = phase;
    if (rti) begin
      if (m_stack.size() > 0) begin
        f = m_stack.pop_back();
        m_insvc[f.id] = 1'b0;
        ret_q.push_back('{up, f.pc, f.id});
      end else begin
        m_err = 1'b1;
      end
    end
    if (old_phase == 0 && instr_boundary && !rti && sel >= 0) begin
      take_q.push_back('{up, 8'h00, sel});
      m_stack.push_back('{pm_address, sel});
      m_insvc[sel] = 1'b1;
      m_pend[sel]  = 1'b0;
      phase = 1;
    end else if (old_phase == 1) begin
      phase = 2;
    end else if (old_phase == 2 && instr_boundary) begin
      phase = 0;
    end
    m_pend = m_pend | rise_m;
    if (mask_we) m_mask = mask_data;
    p3 = p2; p2 = p1; p1 = irq_in;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_take_a", take_a, 0);
    check("rst_vec_a", vec_a, 0);
    check("rst_rv_a", rv_a, 0);
    check("rst_ra_a", ra_a, 0);
    check("rst_isv_a", isv_a, 0);
    check("rst_mask_a", msk_a, 0);
    check("rst_err_a", err_a, 0);
    check("rst_take_b", take_b, 0);
    check("rst_vec_b", vec_b, 0);
  endtask

  exp_t e;

  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      if (take_q.size() > 0 && take_q[0].at == edge_n) begin
        e = take_q.pop_front();
        check("take_a", take_a, 1);
        check("vector_a", vec_a, vec(240, e.id));
        check("take_b", take_b, 1);
        check("vector_b_wrap", vec_b, vec(254, e.id));
      end else begin
        check("no_take_a", take_a, 0);
        check("no_take_b", take_b, 0);
      end
      if (ret_q.size() > 0 && ret_q[0].at == edge_n) begin
        e = ret_q.pop_front();
        check("ret_valid_a", rv_a, 1);
        check("ret_addr_a", ra_a, e.val);
        check("ret_valid_b", rv_b, 1);
        check("ret_addr_b", ra_b, e.val);
      end else begin
        check("no_ret_a", rv_a, 0);
        check("no_ret_b", rv_b, 0);
      end
      check("in_service_a", isv_a, m_insvc);
      check("in_service_b", isv_b, m_insvc);
      check("mask_reg", msk_a, m_mask);
      check("err_underflow_a", err_a, m_err);
      check("err_underflow_b", err_b, m_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [3:0] irq, input logic mwe, input logic [3:0] md,
                       input logic [7:0] pc, input logic bnd, input logic r);
    @(negedge clk);
    irq_in         = irq;
    mask_we        = mwe;
    mask_data      = md;
    pm_address     = pc;
    instr_boundary = bnd;
    rti            = r;
    model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(cur_irq, 1'b0, 4'h0, 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic bnd(input logic [7:0] pc);
    drive(cur_irq, 1'b0, 4'h0, pc, 1'b1, 1'b0);
  endtask

  task automatic do_rti();
    drive(cur_irq, 1'b0, 4'h0, 8'($urandom), 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    mon_on = 1'b0;
    model_reset();
    @(negedge clk);
    irq_in = cur_irq; mask_we = 1'b0; mask_data = '0;
    instr_boundary = 1'b0; rti = 1'b0;
    reset  = 1'b0;
    mon_on = 1'b1;
    model_step();
  endtask

  logic [3:0] flip;

  initial begin
    reset = 1'b1;
    irq_in = '0; mask_we = 1'b0; mask_data = '0; pm_address = '0;
    instr_boundary = 1'b0; rti = 1'b0;
    cur_irq = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset  = 1'b0;
    mon_on = 1'b1;
    model_step();

    // rti with an empty stack
    do_rti();
    idle(2);

    // single request on line 2
    cur_irq = 4'b0100; idle(4);
    bnd(8'h37); idle(3);
    do_rti(); idle(2);

    // priority: lines 3 and 1 together
    cur_irq = 4'b0000; idle(3);
    cur_irq = 4'b1010; idle(4);
    bnd(8'h20); idle(2); bnd(8'h21);
    do_rti(); bnd(8'h22); idle(2); bnd(8'h23);
    do_rti(); idle(2);

    // nesting: line 2 then line 0, with line 3 waiting
    cur_irq = 4'b0000; idle(3);
    cur_irq = 4'b0100; idle(4);
    bnd(8'h10); idle(2); bnd(8'h11);
    cur_irq = 4'b1101; idle(4);
    bnd(8'h55); idle(2); bnd(8'h56);
    do_rti(); bnd(8'h57);
    do_rti(); bnd(8'h58); idle(2); bnd(8'h59);
    do_rti(); idle(2);

    // mask blocks line 0 until cleared
    cur_irq = 4'b0000; idle(3);
    drive(cur_irq, 1'b1, 4'b0001, 8'h00, 1'b0, 1'b0);
    cur_irq = 4'b0001; idle(4);
    bnd(8'h60); bnd(8'h61);
    drive(cur_irq, 1'b1, 4'b0000, 8'h62, 1'b0, 1'b0);
    bnd(8'h63); idle(2); bnd(8'h64);
    do_rti(); idle(2);

    // rti collides with an eligible boundary
    cur_irq = 4'b0000; idle(3);
    cur_irq = 4'b1000; idle(4);
    bnd(8'h44); idle(2); bnd(8'h45);
    cur_irq = 4'b1010; idle(4);
    drive(cur_irq, 1'b0, 4'h0, 8'h46, 1'b1, 1'b1);
    bnd(8'h47); idle(2); bnd(8'h48);
    do_rti(); idle(2);

    // randomized traffic
    for (int k = 0; k < 2500; k++) begin
      flip    = 4'($urandom) & 4'($urandom) & 4'($urandom);
      cur_irq = cur_irq ^ flip;
      drive(cur_irq, ($urandom % 16) == 0, 4'($urandom) & 4'($urandom),
            8'($urandom), 1'($urandom), ($urandom % 8) == 0);
    end

    // reset applied while the take pulse is high
    cur_irq = 4'b0000;
    do_reset();
    idle(3);
    cur_irq = 4'b0010; idle(4);
    bnd(8'h70);
    @(posedge clk);
    #2;
    check("vector_before_reset", take_a, 1);
    reset  = 1'b1;
    mon_on = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    irq_in = cur_irq; mask_we = 1'b0; instr_boundary = 1'b0; rti = 1'b0;
    reset  = 1'b0;
    mon_on = 1'b1;
    model_step();
    // line held high through release yields one fresh request
    idle(5);
    bnd(8'h71); idle(2); bnd(8'h72);
    do_rti(); idle(3);

    check("take_queue_drained", take_q.size(), 0);
    check("ret_queue_drained", ret_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
